// File: rtl/psum_writeback_if.sv
//============================================================================
// Module      : psum_writeback_if
// Description : Job-control, OFIFO handshake and SRAM-bank signals of the
//               partial-sum writeback engine.
//   Controller side (master) drives: start, num_rows, rd_base, wr_base,
//                                    acc, valid
//   Engine side (slave) drives     : ofifo_rd, sfu_en, rd_cen, rd_a, wr_cen,
//                                    wr_wen, wr_a, busy, done
//                                    (+ stall_cnt when PSUM_WB_PERF_EN)
//   Optional feature macro         : PSUM_WB_PERF_EN
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

interface psum_writeback_if #(
  parameter int addr_bw = 7
);
  logic               start;
  logic [addr_bw:0]   num_rows;
  logic [addr_bw-1:0] rd_base;
  logic [addr_bw-1:0] wr_base;
  logic               acc;
  logic               valid;
  logic               ofifo_rd;
  logic               sfu_en;
  logic               rd_cen;
  logic [addr_bw-1:0] rd_a;
  logic               wr_cen;
  logic               wr_wen;
  logic [addr_bw-1:0] wr_a;
  logic               busy;
  logic               done;
`ifdef PSUM_WB_PERF_EN
  logic [15:0]        stall_cnt;
`endif

  modport master (
    output start, num_rows, rd_base, wr_base, acc, valid,
    input  ofifo_rd, sfu_en, rd_cen, rd_a, wr_cen, wr_wen, wr_a, busy, done
`ifdef PSUM_WB_PERF_EN
    , input stall_cnt
`endif
  );

  modport slave (
    input  start, num_rows, rd_base, wr_base, acc, valid,
    output ofifo_rd, sfu_en, rd_cen, rd_a, wr_cen, wr_wen, wr_a, busy, done
`ifdef PSUM_WB_PERF_EN
    , output stall_cnt
`endif
  );
endinterface

`default_nettype wire

// File: rtl/psum_writeback.sv
//============================================================================
// Module      : psum_writeback
// Description : Drains num_rows psum rows from the OFIFO into an output SRAM
//               bank, optionally accumulating with a stored psum read from a
//               source bank through the SFU. Each pop launches a write that
//               lands exactly wr_lat cycles later.
// Ports       : clk   - clock, rising edge
//               reset - synchronous, active-high
//               bus   - psum_writeback_if.slave (job control, OFIFO
//                       handshake, source/destination bank controls)
// Config      : define PSUM_WB_PERF_EN to add bus.stall_cnt, a saturating
//               count of DRAIN cycles spent waiting on an empty OFIFO.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module psum_writeback #(
  parameter int col     = 8,
  parameter int psum_bw = 32,
  parameter int addr_bw = 7,
  parameter int wr_lat  = 3
) (
  input  wire logic       clk,
  input  wire logic       reset,
  psum_writeback_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam logic [addr_bw:0] c_one = {{addr_bw{1'b0}}, 1'b1};

  generate
    if (wr_lat < 1 || col < 1 || psum_bw < 1) begin : g_bad_cfg
      $error("psum_writeback: wr_lat, col and psum_bw must all be >= 1");
    end
  endgenerate

  logic [1:0]         r_state;
  logic [addr_bw:0]   r_issued;
  logic [addr_bw:0]   r_num_rows;
  logic [addr_bw-1:0] r_rd_base;
  logic [addr_bw-1:0] r_wr_base;
  logic               r_acc;
  logic [wr_lat-1:0]  r_pipe_v;
  logic [addr_bw-1:0] r_pipe_a [wr_lat];

  logic               w_pop;
  logic               w_rd_en;
  logic               w_wr_fire;
  logic [addr_bw-1:0] w_offset;
  logic [addr_bw-1:0] w_rd_addr;
  logic [addr_bw-1:0] w_wr_addr;

  // Outputs are gated with reset so the bank controls are idle during the
  // reset cycle itself, before the registered state has been cleared.
  assign w_pop     = !reset && (r_state == S_DRAIN) && bus.valid &&
                     (r_issued < r_num_rows);
  assign w_rd_en   = w_pop && r_acc;
  assign w_wr_fire = !reset && r_pipe_v[wr_lat-1];
  // Truncation to addr_bw bits gives the modulo-2^addr_bw address wrap.
  assign w_offset  = r_issued[addr_bw-1:0];
  assign w_rd_addr = r_rd_base + w_offset;
  assign w_wr_addr = r_wr_base + w_offset;

  assign bus.ofifo_rd = w_pop;
  assign bus.rd_cen   = !w_rd_en;
  assign bus.rd_a     = w_rd_en ? w_rd_addr : '0;
  assign bus.wr_cen   = !w_wr_fire;
  assign bus.wr_wen   = !w_wr_fire;
  assign bus.wr_a     = w_wr_fire ? r_pipe_a[wr_lat-1] : '0;
  assign bus.busy     = !reset && (r_state != S_IDLE);
  assign bus.done     = !reset && (r_state == S_FIN);
  assign bus.sfu_en   = !reset && r_acc &&
                        ((r_state == S_DRAIN) || (r_state == S_FLUSH));

  // Control FSM and job registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_issued   <= '0;
      r_num_rows <= '0;
      r_rd_base  <= '0;
      r_wr_base  <= '0;
      r_acc      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_num_rows <= bus.num_rows;
            r_rd_base  <= bus.rd_base;
            r_wr_base  <= bus.wr_base;
            r_acc      <= bus.acc;
            r_issued   <= '0;
            r_state    <= (bus.num_rows == '0) ? S_FIN : S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_pop) begin
            r_issued <= r_issued + c_one;
          end
          if (r_issued == r_num_rows) begin
            r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (r_pipe_v == '0) begin
            r_state <= S_FIN;
          end
        end
        default: begin
          // FIN: done pulses for this single cycle; a start here is dropped.
          r_acc   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Write-launch pipeline: stage 0 captures the pop, the last stage fires.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pipe_v <= '0;
      for (int i = 0; i < wr_lat; i++) begin
        r_pipe_a[i] <= '0;
      end
    end else begin
      r_pipe_v[0] <= w_pop;
      r_pipe_a[0] <= w_wr_addr;
      for (int i = 1; i < wr_lat; i++) begin
        r_pipe_v[i] <= r_pipe_v[i-1];
        r_pipe_a[i] <= r_pipe_a[i-1];
      end
    end
  end

`ifdef PSUM_WB_PERF_EN
  logic [15:0] r_stall_cnt;

  // Only cycles that still owe a pop count as stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (r_state == S_IDLE && bus.start) begin
      r_stall_cnt <= '0;
    end else if (r_state == S_DRAIN && !bus.valid &&
                 (r_issued < r_num_rows) && r_stall_cnt != 16'hFFFF) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_psum_writeback.sv
//============================================================================
// Module      : tb_psum_writeback
// Description : Directed self-checking bench for psum_writeback
//               (addr_bw=7, wr_lat=3). Honours PSUM_WB_PERF_EN.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_psum_writeback;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  psum_writeback_if #(.addr_bw(7)) bus ();

  psum_writeback #(
    .col     (8),
    .psum_bw (32),
    .addr_bw (7),
    .wr_lat  (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic ck(input string tag, input logic [31:0] obs,
                    input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Outputs that must sit at their quiet values (reset / idle).
  task automatic ck_quiet(input string tag);
    ck({tag, ".ofifo_rd"}, 32'(bus.ofifo_rd), 0);
    ck({tag, ".sfu_en"},   32'(bus.sfu_en),   0);
    ck({tag, ".busy"},     32'(bus.busy),     0);
    ck({tag, ".done"},     32'(bus.done),     0);
    ck({tag, ".rd_cen"},   32'(bus.rd_cen),   1);
    ck({tag, ".wr_cen"},   32'(bus.wr_cen),   1);
    ck({tag, ".wr_wen"},   32'(bus.wr_wen),   1);
    ck({tag, ".rd_a"},     32'(bus.rd_a),     0);
    ck({tag, ".wr_a"},     32'(bus.wr_a),     0);
  endtask

  // Job with valid held high. Cycle 0 is the start cycle: pops in cycles
  // 1..n, writes in 4..n+3, done at n+5 (or 1 when n=0). A stray start is
  // raised in cycle poke_c and must be ignored.
  task automatic run_job(input int n, input int rb, input int wb,
                         input bit a, input int poke_c);
    int  d;
    bit  pop, wr;
    string t;
    d = (n == 0) ? 1 : n + 5;
    for (int c = 0; c <= d + 1; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        bus.start    = 1'b1;
        bus.num_rows = 8'(n);
        bus.rd_base  = 7'(rb);
        bus.wr_base  = 7'(wb);
        bus.acc      = a;
        bus.valid    = 1'b1;
      end else begin
        bus.start = (c == poke_c);
        if (c == poke_c) bus.num_rows = 8'd1;
      end
      #1;
      t   = $sformatf("job(n=%0d,wb=%0d) c%0d", n, wb, c);
      pop = (c >= 1) && (c <= n);
      wr  = (c >= 4) && (c <= n + 3);
      ck({t, ".ofifo_rd"}, 32'(bus.ofifo_rd), 32'(pop));
      ck({t, ".rd_cen"},   32'(bus.rd_cen),   32'(!(pop && a)));
      if (pop && a) ck({t, ".rd_a"}, 32'(bus.rd_a), (rb + c - 1) % 128);
      ck({t, ".wr_cen"},   32'(bus.wr_cen),   32'(!wr));
      ck({t, ".wr_wen"},   32'(bus.wr_wen),   32'(!wr));
      if (wr) ck({t, ".wr_a"}, 32'(bus.wr_a), (wb + c - 4) % 128);
      ck({t, ".done"},     32'(bus.done),     32'(c == d));
      ck({t, ".busy"},     32'(bus.busy),     32'((c >= 1) && (c <= d)));
      ck({t, ".sfu_en"},   32'(bus.sfu_en),   32'(a && (c >= 1) && (c < d)));
    end
    bus.start = 1'b0;
    bus.valid = 1'b0;
  endtask

  initial begin
    bit    pop, wr;
    int    wa;
    string t;
    n_checks = 0;
    n_fail   = 0;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.num_rows = '0;
    bus.rd_base  = '0;
    bus.wr_base  = '0;
    bus.acc      = 1'b0;
    bus.valid    = 1'b0;

    // Reset state, during and on the cycle after reset
    repeat (2) @(posedge clk);
    #2;
    ck_quiet("in_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    ck_quiet("after_reset");

    // Basic drain, overwrite mode; stray start mid-job
    run_job(4, 0, 0, 1'b0, 2);
    // Accumulate path with distinct bases
    run_job(2, 5, 9, 1'b1, 0);
    // Destination address wrap 126,127,0,1
    run_job(4, 0, 126, 1'b0, 0);
    // Empty job; start in the FIN cycle must be ignored
    run_job(0, 0, 0, 1'b0, 1);

    // Bubbly OFIFO: valid 1,0,0,1,1 -> pops c1,c4,c5; writes c4,c7,c8
    for (int c = 0; c <= 11; c++) begin
      @(posedge clk); #1;
      bus.start = (c == 0);
      if (c == 0) begin
        bus.num_rows = 8'd3;
        bus.rd_base  = 7'd0;
        bus.wr_base  = 7'd20;
        bus.acc      = 1'b0;
      end
      bus.valid = (c == 1) || (c == 4) || (c == 5);
      #1;
      t   = $sformatf("bubble c%0d", c);
      pop = (c == 1) || (c == 4) || (c == 5);
      wr  = (c == 4) || (c == 7) || (c == 8);
      wa  = (c == 4) ? 20 : (c == 7) ? 21 : 22;
      ck({t, ".ofifo_rd"}, 32'(bus.ofifo_rd), 32'(pop));
      ck({t, ".wr_cen"},   32'(bus.wr_cen),   32'(!wr));
      if (wr) ck({t, ".wr_a"}, 32'(bus.wr_a), wa);
      ck({t, ".done"},     32'(bus.done),     32'(c == 10));
    end
`ifdef PSUM_WB_PERF_EN
    ck("bubble.stall_cnt", 32'(bus.stall_cnt), 2);
`endif

    // Reset one cycle after the 2nd pop of a 4-row job
    for (int c = 0; c <= 9; c++) begin
      @(posedge clk); #1;
      bus.start = (c == 0);
      if (c == 0) begin
        bus.num_rows = 8'd4;
        bus.rd_base  = 7'd0;
        bus.wr_base  = 7'd40;
        bus.acc      = 1'b1;
      end
      bus.valid = 1'b1;
      reset     = (c == 3);
      #1;
      t = $sformatf("midreset c%0d", c);
      if (c >= 3) begin
        ck_quiet(t);
      end else begin
        ck({t, ".ofifo_rd"}, 32'(bus.ofifo_rd), 32'(c >= 1));
        ck({t, ".busy"},     32'(bus.busy),     32'(c >= 1));
      end
    end
    bus.valid = 1'b0;
    // Clean run afterwards
    run_job(3, 10, 50, 1'b1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  // Hard stop in case something stalls the sequence above
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
